// File: rtl/multi_timer_if.sv
// multi_timer bus interface: address, write strobe and per-channel irq pair.
// The bidirectional data bus stays a plain inout port on the timer.
interface multi_timer_if #(
  parameter int NUM_CH = 2
);
  logic [7:0]        BUS_ADDR;
  logic              BUS_WE;
  logic [NUM_CH-1:0] BUS_INTERRUPTS_RAISE;
  logic [NUM_CH-1:0] BUS_INTERRUPTS_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPTS_ACK,
    input  BUS_INTERRUPTS_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPTS_ACK,
    output BUS_INTERRUPTS_RAISE
  );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH 16-bit interval timers on a shared prescaler and 8-bit bus.
// Define MULTI_TIMER_OVERRUN_EN to build the sticky STATUS.OVERRUN flag.
module multi_timer #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_CH    = 2,
  parameter int         PRESCALE  = 100000
) (
  input  logic          CLK,
  input  logic          RESET,
  inout  wire  [7:0]    BUS_DATA,
  multi_timer_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]              presc_q, presc_d;
  logic                       tick;
  logic [NUM_CH-1:0][2:0]     ctrl_q, ctrl_d;
  logic [NUM_CH-1:0][15:0]    shadow_q, shadow_d;
  logic [NUM_CH-1:0][15:0]    period_q, period_d;
  logic [NUM_CH-1:0][15:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]          exp_q, exp_d;
  logic [NUM_CH-1:0]          raise_q, raise_d;
  logic [NUM_CH-1:0]          ovr_q;
`ifdef MULTI_TIMER_OVERRUN_EN
  logic [NUM_CH-1:0]          ovr_d;
`else
  assign ovr_q = '0;
`endif
  logic                       rd_oe_q, rd_oe_d;
  logic [7:0]                 rd_data_q, rd_data_d;

  logic [7:0] off;
  logic       in_win;
  logic [1:0] ch;
  logic [1:0] k;
  logic       wr_en;
  logic       expire;

  assign off    = bus.BUS_ADDR - BASE_ADDR;
  assign in_win = off < 8'(4 * NUM_CH);
  assign ch     = off[3:2];
  assign k      = off[1:0];
  assign wr_en  = bus.BUS_WE && in_win;
  assign tick   = presc_q == PW'(PRESCALE - 1);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    ctrl_d    = ctrl_q;
    shadow_d  = shadow_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    raise_d   = raise_q;
`ifdef MULTI_TIMER_OVERRUN_EN
    ovr_d     = ovr_q;
`endif
    rd_oe_d   = !bus.BUS_WE && in_win;
    rd_data_d = 8'h00;
    expire    = 1'b0;

    for (int c = 0; c < NUM_CH; c++) begin
      expire = 1'b0;
      if (tick && ctrl_q[c][0] && period_q[c] != 16'd0) begin
        if (cnt_q[c] == period_q[c] - 16'd1) begin
          expire      = 1'b1;
          cnt_d[c]    = 16'd0;
          exp_d[c]    = 1'b1;
          period_d[c] = shadow_q[c];
          if (ctrl_q[c][1])
            ctrl_d[c][0] = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] + 16'd1;
        end
      end
      // a fresh expiry beats a simultaneous acknowledge
      if (bus.BUS_INTERRUPTS_ACK[c])
        raise_d[c] = 1'b0;
      if (expire && ctrl_q[c][2])
        raise_d[c] = 1'b1;
`ifdef MULTI_TIMER_OVERRUN_EN
      if (expire && raise_q[c])
        ovr_d[c] = 1'b1;
`endif

      if (wr_en && ch == 2'(c)) begin
        unique case (k)
          2'd0: begin
            ctrl_d[c] = BUS_DATA[2:0];
            if (!ctrl_q[c][0] && BUS_DATA[0]) begin
              period_d[c] = shadow_q[c];
              cnt_d[c]    = 16'd0;
            end
          end
          2'd1: shadow_d[c][7:0]  = BUS_DATA;
          2'd2: shadow_d[c][15:8] = BUS_DATA;
          2'd3: begin
            exp_d[c] = 1'b0;
            cnt_d[c] = 16'd0;
`ifdef MULTI_TIMER_OVERRUN_EN
            ovr_d[c] = 1'b0;
`endif
          end
          default: ;
        endcase
      end

      if (ch == 2'(c)) begin
        unique case (k)
          2'd0: rd_data_d = {5'd0, ctrl_q[c]};
          2'd1: rd_data_d = shadow_q[c][7:0];
          2'd2: rd_data_d = shadow_q[c][15:8];
          2'd3: rd_data_d = {5'd0, ovr_q[c], ctrl_q[c][0], exp_q[c]};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q   <= '0;
      ctrl_q    <= '0;
      shadow_q  <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      raise_q   <= '0;
      rd_oe_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      presc_q   <= presc_d;
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      raise_q   <= raise_d;
      rd_oe_q   <= rd_oe_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef MULTI_TIMER_OVERRUN_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      ovr_q <= '0;
    else
      ovr_q <= ovr_d;
  end
`endif

  assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hzz;
  assign bus.BUS_INTERRUPTS_RAISE = raise_q;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed bench for multi_timer, PRESCALE=4, NUM_CH=2.
// Checks reset state, periodic/one-shot expiry, irq handshake and reset.
module tb_multi_timer;

  logic       clk;
  logic       rst;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  multi_timer_if #(.NUM_CH(2)) bus ();

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  multi_timer #(
    .BASE_ADDR (8'hF0),
    .NUM_CH    (2),
    .PRESCALE  (4)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .BUS_DATA (bus_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b1;
    tb_wdata     = d;
    tb_drv       = 1'b1;
    @(negedge clk);
    bus.BUS_WE   = 1'b0;
    tb_drv       = 1'b0;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b0;
    @(negedge clk);
    d = bus_data;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic wait_rise(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.BUS_INTERRUPTS_RAISE[c]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack(input int c);
    bus.BUS_INTERRUPTS_ACK[c] = 1'b1;
    @(negedge clk);
    bus.BUS_INTERRUPTS_ACK[c] = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 40 && cyc != target; i++)
      @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         ok;
    int         tw, t0, t1, t2, nr;

    rst = 1'b1;
    tb_drv = 1'b0;
    tb_wdata = 8'h00;
    bus.BUS_ADDR = 8'h00;
    bus.BUS_WE = 1'b0;
    bus.BUS_INTERRUPTS_ACK = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_raise", 32'(bus.BUS_INTERRUPTS_RAISE), 0);
    for (int i = 0; i < 8; i++) begin
      bus_read(8'hF0 + 8'(i), d);
      chk($sformatf("rst_rd_%0d", i), 32'(d), 0);
    end

    bus_write(8'hF1, 8'd3);
    bus_write(8'hF2, 8'd0);
    bus_write(8'hF0, 8'h05);
    tw = cyc;
    wait_rise(0, 30, ok);
    t0 = cyc;
    chk("ch0_rise1", 32'(ok), 1);
    chk("ch0_first_lat", 32'((t0 - tw) >= 9 && (t0 - tw) <= 15), 1);
    ack(0);
    chk("ch0_ack", 32'(bus.BUS_INTERRUPTS_RAISE[0]), 0);
    wait_rise(0, 30, ok);
    t1 = cyc;
    chk("ch0_rise2", 32'(ok), 1);
    chk("ch0_period", 32'(t1 - t0), 12);

    wait_cyc(t1 + 11);
    bus.BUS_INTERRUPTS_ACK[0] = 1'b1;
    @(negedge clk);
    chk("ack_coincide", 32'(bus.BUS_INTERRUPTS_RAISE[0]), 1);
    @(negedge clk);
    bus.BUS_INTERRUPTS_ACK[0] = 1'b0;
    chk("ack_clear", 32'(bus.BUS_INTERRUPTS_RAISE[0]), 0);
    bus_read(8'hF3, d);
`ifdef MULTI_TIMER_OVERRUN_EN
    chk("ch0_status_ovr", 32'(d), 32'h07);
`else
    chk("ch0_status", 32'(d), 32'h03);
`endif
    bus_write(8'hF3, 8'h00);
    bus_read(8'hF3, d);
    chk("ch0_status_clr", 32'(d), 32'h02);
    bus_write(8'hF0, 8'h00);

    bus_write(8'hF5, 8'd2);
    bus_write(8'hF4, 8'h07);
    wait_rise(1, 20, ok);
    chk("ch1_rise", 32'(ok), 1);
    ack(1);
    bus_read(8'hF7, d);
    chk("ch1_status", 32'(d), 32'h01);
    @(negedge clk);
    chk("ch1_hiz", 32'(bus_data !== 8'h01), 1);
    bus_read(8'hF4, d);
    chk("ch1_ctrl", 32'(d), 32'h06);
    nr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.BUS_INTERRUPTS_RAISE[1]) nr++;
    end
    chk("ch1_no_rerun", 32'(nr), 0);
    bus_write(8'hF7, 8'h00);
    bus_read(8'hF7, d);
    chk("ch1_status_clr", 32'(d), 32'h00);

    bus_write(8'hF1, 8'd5);
    bus_write(8'hF0, 8'h05);
    wait_rise(0, 40, ok);
    t0 = cyc;
    chk("p5_rise", 32'(ok), 1);
    ack(0);
    wait_cyc(t0 + 6);
    bus_write(8'hF1, 8'd2);
    wait_rise(0, 40, ok);
    t1 = cyc;
    chk("p5_interval", 32'(t1 - t0), 20);
    ack(0);
    wait_rise(0, 40, ok);
    t2 = cyc;
    chk("p2_interval", 32'(t2 - t1), 8);

    @(negedge clk);
    bus.BUS_ADDR = 8'hF0;
    bus.BUS_WE = 1'b0;
    @(negedge clk);
    chk("rd_before_rst", 32'(bus_data), 32'h05);
    chk("raise_before_rst", 32'(bus.BUS_INTERRUPTS_RAISE[0]), 1);
    rst = 1'b1;
    bus.BUS_ADDR = 8'h00;
    @(negedge clk);
    chk("rst_raise_mid", 32'(bus.BUS_INTERRUPTS_RAISE), 0);
    chk("rst_hiz", 32'(bus_data !== 8'h05), 1);
    rst = 1'b0;
    bus_read(8'hF0, d);
    chk("rst_ctrl", 32'(d), 0);
    bus_read(8'hF1, d);
    chk("rst_period", 32'(d), 0);
    bus_read(8'hF3, d);
    chk("rst_status", 32'(d), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the single-channel bus timer: NUM_CH independent 16-bit interval timers.
- All channels share one prescaler and sit on the 8-bit processor data bus at BASE_ADDR.
- Each channel supports periodic or one-shot mode and has its own raise/ack interrupt pair into the processor's interrupt lines.
- Replaces the fixed-period timer where several time bases are needed, e.g. a mouse poll tick plus a display refresh tick.

Parameters:
- BASE_ADDR, 8'hF0, first bus address; channel c occupies BASE_ADDR+4c .. BASE_ADDR+4c+3.
- NUM_CH, 2, number of channels, legal 1..4.
- PRESCALE, 100000, CLK cycles per tick (1 ms at 100 MHz), legal >= 2.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during this block's read cycle, else high-Z.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable; high means write.
- BUS_INTERRUPTS_RAISE  output  NUM_CH  per-channel interrupt request, level.
- BUS_INTERRUPTS_ACK  input  NUM_CH  per-channel acknowledge, 1-cycle pulse from the processor.

Behaviour:
- Register map, offset k within channel c:
  - k=0 CTRL (R/W): bit0 EN, bit1 ONESHOT, bit2 IRQ_EN; bits7:3 read 0.
  - k=1 PERIOD_LO (R/W).
  - k=2 PERIOD_HI (R/W).
  - k=3 STATUS: read bit0 EXPIRED (sticky), bit1 = EN, bit2 OVERRUN (optional feature), other bits 0. Any write clears EXPIRED and OVERRUN and zeroes the channel counter.
- Writes: take effect on the CLK edge where BUS_WE=1 and the address matches.
- Reads: when BUS_WE=0 and the address matches, read data and output enable are registered; BUS_DATA is driven exactly one cycle later, for one cycle, then returns to high-Z. Unmapped addresses in the window (channel index >= NUM_CH) never drive the bus.
- Prescaler: free-running counter 0..PRESCALE-1. TICK pulses for one cycle when it wraps. Runs continuously after reset, independent of channel enables.
- PERIOD writes land in a shadow register. The active period loads from the shadow when the channel is enabled from idle (EN 0->1) and at every wrap. A write while running therefore takes effect at the next expiry.
- Counter, per channel: on TICK with EN=1 and active period P>0:
  - if count == P-1, the channel expires: count <- 0, EXPIRED <- 1, and if IRQ_EN then RAISE <- 1.
  - otherwise count increments.
- P=0: the counter holds at 0 and never expires.
- ONESHOT=1: the expiry also clears EN, so the counter stops at 0.
- EN=0: the count is held. Re-enabling restarts the count from 0.
- Interrupt handshake:
  - RAISE stays high until ACK[c]=1, and clears on that edge.
  - If expiry and ACK coincide in the same cycle, RAISE stays 1 (new event wins).
  - ACK with RAISE=0 is ignored.
  - Clearing IRQ_EN does not drop a pending RAISE.
- Expiry period: first expiry occurs P ticks after enable, with a prescaler phase uncertainty of up to PRESCALE-1 cycles.
- Reset, applied at any time including mid-count or mid-read:
  - all CTRL, PERIOD, counter, prescaler, STATUS and RAISE state go to 0;
  - the bus output enable goes to 0 (BUS_DATA high-Z on the next edge).

Optional Feature:
- Macro: MULTI_TIMER_OVERRUN_EN.
- Defined: STATUS bit2 OVERRUN is set when a channel expires while its RAISE is still high (interrupt missed). It is sticky and cleared by a STATUS write or by reset.
- Undefined: bit2 reads 0 and no overrun logic is synthesised.

Test Plan:
- Reset, then read each of the 8 addresses BASE..BASE+7 with NUM_CH=2 -> every read returns 8'h00 one cycle after the address; BUS_DATA is high-Z in all other cycles; RAISE=2'b00.
- PRESCALE=4. Ch0: PERIOD=3, CTRL=8'h05 (EN, IRQ_EN) -> RAISE[0] rises 12 cycles (±3) after enable. ACK[0] pulse -> RAISE[0]=0 next cycle. Next rise follows 12 cycles after the previous one.
- Ch1 one-shot: PERIOD=2, CTRL=8'h07 -> a single RAISE[1] and STATUS=8'h01 (EN cleared); no further expiry over 100 cycles. A STATUS write then clears it to 8'h00.
- Ch0 running at PERIOD=5; write PERIOD=2 mid-count -> the current interval still lasts 5 ticks and subsequent intervals last 2 ticks.
- Hold ACK[0] asserted on the exact cycle of a new expiry -> RAISE[0] stays 1. With MULTI_TIMER_OVERRUN_EN, letting two expiries pass without ACK -> STATUS bit2=1.
- Assert RESET while ch0 is counting and during a read cycle -> next cycle all RAISE=0, BUS_DATA high-Z; CTRL reads 8'h00 after RESET deasserts.
